// File: rtl/stream_stats_dpcp.sv
// Per-block statistic (sum, sum of |x|, max, min) over COUNT signed samples.
// Result registered on the last accept; valid the next cycle, held until result_ready.
module stream_stats_dpcp #(
  parameter  int WIDTH = 8,
  parameter  int COUNT = 8,
  localparam int CNTW  = $clog2(COUNT),
  localparam int ACCW  = WIDTH + CNTW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic signed [WIDTH-1:0] datain,
  input  logic                   datain_valid,
  output logic                   datain_ready,
  output logic signed [ACCW-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [CNTW:0] LAST_IDX = (CNTW+1)'(COUNT - 1);

  state_t                 state_q;
  logic [1:0]             mode_q;
  logic [CNTW:0]          cnt_q;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] result_q;
  logic                   ready_q, valid_q, busy_q;

  logic                   accept;
  logic signed [WIDTH:0]  x_ext, x_abs;
  logic signed [ACCW-1:0] x_acc, abs_acc, term;

  assign accept = ready_q && datain_valid;

  // |x| at WIDTH+1 bits keeps |-2^(WIDTH-1)| exact; it is non-negative so zero-extend.
  always_comb begin
    x_ext   = {datain[WIDTH-1], datain};
    x_abs   = x_ext[WIDTH] ? -x_ext : x_ext;
    x_acc   = {{(ACCW-WIDTH){datain[WIDTH-1]}}, datain};
    abs_acc = {{(ACCW-WIDTH-1){1'b0}}, x_abs};
    term    = (mode_q == 2'd1) ? abs_acc : x_acc;
    acc_d   = acc_q;
    if (cnt_q == '0) begin
      acc_d = term;
    end else begin
      case (mode_q)
        2'd0, 2'd1: acc_d = acc_q + term;
        2'd2:       acc_d = (x_acc > acc_q) ? x_acc : acc_q;
        default:    acc_d = (x_acc < acc_q) ? x_acc : acc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            cnt_q   <= '0;
            state_q <= S_LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              result_q <= acc_d;
              state_q  <= S_DONE;
              ready_q  <= 1'b0;
              valid_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (result_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign datain_ready = ready_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign busy         = busy_q;

endmodule

// File: doc/stream_stats_dpcp.md
Name: stream_stats_dpcp

Overview:
Parametrised datapath/controlpath block that consumes a fixed-length block of COUNT signed samples and produces one statistic per block. The statistic is one of: sum, sum of absolute values, maximum or minimum, selected per block. It is the generalised successor to the fixed 8-bit single-function datapath/controlpath top: width and block length are parametrised, mode is selectable at run time, and both input and output use valid/ready handshakes. It sits between a sample source and a result consumer within one clock domain.

Parameters:
WIDTH, 8, sample width in bits; two's-complement signed.
COUNT, 8, samples per block; must be at least 2.
CNTW, $clog2(COUNT), derived localparam; sample counter width is CNTW+1.
ACCW, WIDTH+CNTW+1, derived localparam; accumulator/result width, signed, cannot overflow.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin a block; sampled only in IDLE
mode  in  2  0=sum, 1=sum of |x|, 2=max, 3=min; latched on accepted start
datain  in  WIDTH  signed sample
datain_valid  in  1  sample present
datain_ready  out  1  block accepts sample this cycle
result  out  ACCW  signed statistic
result_valid  out  1  result held valid
result_ready  in  1  consumer takes result
busy  out  1  high in LOAD or DONE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, acc=0, count=0, mode_q=0, result=0, result_valid=0, datain_ready=0, busy=0.
- FSM states:
  - IDLE: if start=1, latch mode into mode_q, set count=0, and go to LOAD next cycle.
  - LOAD: datain_ready=1 (registered/state-decoded, no combinational path from datain_valid). A sample is accepted when datain_valid and datain_ready are both 1. After COUNT accepted samples, go to DONE.
  - DONE: result_valid=1 and result is stable. On result_ready=1, go to IDLE next cycle and clear result_valid.
- Accept rules:
  - First accepted sample of a block loads acc directly: x for modes 0/2/3, |x| for mode 1.
  - Subsequent samples:
    - mode 0: acc += x.
    - mode 1: acc += |x|.
    - mode 2: acc = max(acc, x).
    - mode 3: acc = min(acc, x).
  - Gaps (datain_valid=0) stall the block with no change to acc or count.
- Arithmetic:
  - Samples are sign-extended to ACCW before use.
  - |x| is computed at WIDTH+1 bits, so |-2^(WIDTH-1)| = 2^(WIDTH-1) exactly.
  - Comparisons are signed.
  - ACCW guarantees no overflow for any input.
- Latency: result is registered on the cycle the COUNT-th sample is accepted. result_valid rises on the next clock edge, i.e. one cycle after the last accept.
- Boundary conditions:
  - start in LOAD/DONE: ignored.
  - mode change mid-block: ignored; mode_q is used.
  - start=1 in the same cycle that DONE exits: ignored; start is honoured only in IDLE, so the earliest next start is the cycle after returning to IDLE.
  - result_ready while not DONE: ignored.
  - result held indefinitely while result_ready=0; datain_ready=0 throughout.
  - result keeps its last value after returning to IDLE until the next block completes.
  - reset asserted mid-block: immediate return to reset values; the partial block is discarded.

Test Plan:
- WIDTH=8, COUNT=8, mode=0, samples -127,-127,30,0,1,2,3,4 streamed one per cycle -> result=-214 (12-bit 0xF2A); result_valid rises 1 cycle after 8th accept.
- Same samples, mode=1 -> result=294. mode=2 -> result=30. mode=3 -> result=-127.
- mode=1, eight samples of -128 -> result=1024 (no overflow). mode=0, eight samples of -128 -> result=-1024.
- mode=0, datain_valid toggling 1,0,0,1,... over the block -> same -214 result; count advances only on accepts; datain_ready stays 1 throughout LOAD.
- Hold result_ready=0 for 10 cycles in DONE while toggling start and mode -> result and result_valid stable, datain_ready=0; then result_ready=1 -> IDLE next cycle.
- Drive reset=0 asynchronously (mid-cycle) after the 4th accept -> all outputs at reset values immediately; after release, a fresh block of 1..8 in mode=0 -> result=36.
